// File: rtl/bridge_wide_narrow.sv
// bridge_wide_narrow: splits one HOST_DW host access into BUS_DW beats on a narrow bus,
// skipping beats with no enabled byte lanes; optional per-beat watchdog flags timeouts.
module bridge_wide_narrow #(
    parameter int HOST_DW = 32,
    parameter int BUS_DW  = 16,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    h_addr,
    input  logic [HOST_DW-1:0]   h_wdata,
    output logic [HOST_DW-1:0]   h_rdata,
    input  logic                 h_wr_en,
    input  logic [HOST_DW/8-1:0] h_bytesel,
    output logic                 h_compl,
    output logic                 h_err,
    output logic [ADDR_W-1:0]    b_addr,
    output logic [BUS_DW-1:0]    b_wdata,
    input  logic [BUS_DW-1:0]    b_rdata,
    output logic                 b_wr_en,
    output logic [BUS_DW/8-1:0]  b_bytesel,
    input  logic                 b_compl
);
    localparam int HB    = HOST_DW / 8;
    localparam int RATIO = HOST_DW / BUS_DW;
    localparam int BB    = BUS_DW / 8;
    localparam int KW    = $clog2(RATIO);
    localparam int LB    = $clog2(BB);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t             r_state, w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [HOST_DW-1:0] r_wdata, r_rdata;
    logic [HB-1:0]      r_bsel;
    logic               r_wr, r_err;
    logic [KW-1:0]      r_k, w_first, w_next_k;
    logic [15:0]        r_wd;
    logic [RATIO-1:0]   w_hgrp, w_rgrp;
    logic               w_more, w_to, w_ack, w_start;

    function automatic logic [RATIO-1:0] groups(input logic [HB-1:0] s);
        logic [RATIO-1:0] g;
        for (int i = 0; i < RATIO; i++) g[i] = |s[i*BB +: BB];
        return g;
    endfunction

    always_comb begin
        w_hgrp   = groups(h_bytesel);
        w_rgrp   = groups(r_bsel);
        w_first  = '0;
        w_next_k = '0;
        w_more   = 1'b0;
        // descending scan so the lowest qualifying group wins
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (w_hgrp[i]) w_first = KW'(i);
            if (w_rgrp[i] && i > int'(r_k)) begin
                w_more   = 1'b1;
                w_next_k = KW'(i);
            end
        end
        w_start = r_state == IDLE && |h_bytesel;
        w_to    = TIMEOUT != 0 && r_state == BEAT && !b_compl && r_wd == 16'(TIMEOUT - 1);
        w_ack   = r_state == BEAT && (b_compl || w_to);
        w_next_state = r_state == IDLE ? (w_start ? BEAT : IDLE) :
                       r_state == BEAT ? (w_ack && !w_more ? DONE : BEAT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_bsel  <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_k     <= '0;
            r_wd    <= '0;
        end else if (w_start) begin
            r_addr  <= h_addr;
            r_wdata <= h_wdata;
            r_wr    <= h_wr_en;
            r_bsel  <= h_bytesel;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_k     <= w_first;
            r_wd    <= '0;
        end else if (r_state == BEAT) begin
            r_wd <= w_ack ? '0 : r_wd + 16'd1;
            if (b_compl && !r_wr) r_rdata[r_k*BUS_DW +: BUS_DW] <= b_rdata;
            if (w_to) r_err <= 1'b1;
            if (w_ack && w_more) r_k <= w_next_k;
        end
    end

    assign b_addr    = (r_addr & ~ADDR_W'(HB - 1)) | (ADDR_W'(r_k) << LB);
    assign b_wdata   = r_wdata[r_k*BUS_DW +: BUS_DW];
    assign b_wr_en   = r_wr;
    assign b_bytesel = r_state == BEAT ? r_bsel[r_k*BB +: BB] : '0;
    assign h_rdata   = r_rdata;
    assign h_compl   = r_state == DONE;
    assign h_err     = r_state == DONE && r_err;
endmodule

// File: tb/tb_bridge_wide_narrow.sv
// tb_bridge_wide_narrow: directed checks of the width bridge in 32/16 (with watchdog),
// 64/16 and 32/8 configurations.
module tb_bridge_wide_narrow;
    logic clk, rst_n;
    int   n_tests, n_fail;

    logic [31:0] ua_h_addr, ua_h_wdata, ua_h_rdata, ua_b_addr;
    logic [15:0] ua_b_wdata, ua_b_rdata;
    logic [3:0]  ua_h_bytesel;
    logic [1:0]  ua_b_bytesel;
    logic        ua_h_wr_en, ua_h_compl, ua_h_err, ua_b_wr_en, ua_b_compl;

    logic [31:0] ub_h_addr, ub_b_addr;
    logic [63:0] ub_h_wdata, ub_h_rdata;
    logic [15:0] ub_b_wdata, ub_b_rdata;
    logic [7:0]  ub_h_bytesel;
    logic [1:0]  ub_b_bytesel;
    logic        ub_h_wr_en, ub_h_compl, ub_h_err, ub_b_wr_en, ub_b_compl;

    logic [31:0] uc_h_addr, uc_h_wdata, uc_h_rdata, uc_b_addr;
    logic [7:0]  uc_b_wdata, uc_b_rdata;
    logic [3:0]  uc_h_bytesel;
    logic [0:0]  uc_b_bytesel;
    logic        uc_h_wr_en, uc_h_compl, uc_h_err, uc_b_wr_en, uc_b_compl;

    bridge_wide_narrow #(.HOST_DW(32), .BUS_DW(16), .ADDR_W(32), .TIMEOUT(4)) u_a (
        .clk(clk), .rst_n(rst_n), .h_addr(ua_h_addr), .h_wdata(ua_h_wdata), .h_rdata(ua_h_rdata),
        .h_wr_en(ua_h_wr_en), .h_bytesel(ua_h_bytesel), .h_compl(ua_h_compl), .h_err(ua_h_err),
        .b_addr(ua_b_addr), .b_wdata(ua_b_wdata), .b_rdata(ua_b_rdata), .b_wr_en(ua_b_wr_en),
        .b_bytesel(ua_b_bytesel), .b_compl(ua_b_compl));

    bridge_wide_narrow #(.HOST_DW(64), .BUS_DW(16), .ADDR_W(32), .TIMEOUT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .h_addr(ub_h_addr), .h_wdata(ub_h_wdata), .h_rdata(ub_h_rdata),
        .h_wr_en(ub_h_wr_en), .h_bytesel(ub_h_bytesel), .h_compl(ub_h_compl), .h_err(ub_h_err),
        .b_addr(ub_b_addr), .b_wdata(ub_b_wdata), .b_rdata(ub_b_rdata), .b_wr_en(ub_b_wr_en),
        .b_bytesel(ub_b_bytesel), .b_compl(ub_b_compl));

    bridge_wide_narrow #(.HOST_DW(32), .BUS_DW(8), .ADDR_W(32), .TIMEOUT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .h_addr(uc_h_addr), .h_wdata(uc_h_wdata), .h_rdata(uc_h_rdata),
        .h_wr_en(uc_h_wr_en), .h_bytesel(uc_h_bytesel), .h_compl(uc_h_compl), .h_err(uc_h_err),
        .b_addr(uc_b_addr), .b_wdata(uc_b_wdata), .b_rdata(uc_b_rdata), .b_wr_en(uc_b_wr_en),
        .b_bytesel(uc_b_bytesel), .b_compl(uc_b_compl));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        {ua_h_addr, ua_h_wdata, ua_b_rdata, ua_h_bytesel, ua_h_wr_en, ua_b_compl} = '0;
        {ub_h_addr, ub_h_wdata, ub_b_rdata, ub_h_bytesel, ub_h_wr_en, ub_b_compl} = '0;
        {uc_h_addr, uc_h_wdata, uc_b_rdata, uc_h_bytesel, uc_h_wr_en, uc_b_compl} = '0;
        repeat (2) @(negedge clk);
        check("rst_bsel",  64'(ua_b_bytesel), 64'h0);
        check("rst_baddr", 64'(ua_b_addr), 64'h0);
        check("rst_compl", 64'(ua_h_compl), 64'h0);
        check("rst_rdata", 64'(ua_h_rdata), 64'h0);
        check("rst_wr",    64'(ua_b_wr_en), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // read, zero wait, two beats
        ua_h_addr = 32'h100; ua_h_bytesel = 4'hF; ua_h_wr_en = 1'b0;
        @(negedge clk);
        ua_h_bytesel = 4'h0;
        check("t1_addr0", 64'(ua_b_addr), 64'h100);
        check("t1_bsel0", 64'(ua_b_bytesel), 64'h3);
        check("t1_nocompl", 64'(ua_h_compl), 64'h0);
        ua_b_compl = 1'b1; ua_b_rdata = 16'h1234;
        @(negedge clk);
        check("t1_addr1", 64'(ua_b_addr), 64'h102);
        check("t1_bsel1", 64'(ua_b_bytesel), 64'h3);
        ua_b_rdata = 16'hABCD;
        @(negedge clk);
        ua_b_compl = 1'b0;
        check("t1_compl", 64'(ua_h_compl), 64'h1);
        check("t1_rdata", 64'(ua_h_rdata), 64'hABCD1234);
        check("t1_err",   64'(ua_h_err), 64'h0);
        check("t1_bsel_done", 64'(ua_b_bytesel), 64'h0);
        @(negedge clk);
        check("t1_compl_pulse", 64'(ua_h_compl), 64'h0);

        // watchdog abandons beat 0 after 4 cycles
        ua_h_addr = 32'h200; ua_h_bytesel = 4'hF;
        @(negedge clk);
        ua_h_bytesel = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("t4_wait_addr", 64'(ua_b_addr), 64'h200);
            check("t4_wait_bsel", 64'(ua_b_bytesel), 64'h3);
            @(negedge clk);
        end
        check("t4_addr1", 64'(ua_b_addr), 64'h202);
        check("t4_nocompl", 64'(ua_h_compl), 64'h0);
        ua_b_compl = 1'b1; ua_b_rdata = 16'h5A5A;
        @(negedge clk);
        ua_b_compl = 1'b0;
        check("t4_compl", 64'(ua_h_compl), 64'h1);
        check("t4_err",   64'(ua_h_err), 64'h1);
        check("t4_rdata", 64'(ua_h_rdata), 64'h5A5A0000);
        @(negedge clk);

        // reset in the middle of beat 1
        ua_h_addr = 32'h500; ua_h_bytesel = 4'hF;
        @(negedge clk);
        ua_h_bytesel = 4'h0;
        ua_b_compl = 1'b1; ua_b_rdata = 16'h1111;
        @(negedge clk);
        ua_b_compl = 1'b0;
        check("t5_addr1", 64'(ua_b_addr), 64'h502);
        rst_n = 1'b0;
        #1;
        check("t5_bsel_async", 64'(ua_b_bytesel), 64'h0);
        check("t5_addr_async", 64'(ua_b_addr), 64'h0);
        check("t5_rdata_async", 64'(ua_h_rdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ua_b_compl = 1'b1;
        @(negedge clk);
        check("t5_stray_bsel", 64'(ua_b_bytesel), 64'h0);
        check("t5_stray_compl", 64'(ua_h_compl), 64'h0);
        ua_b_compl = 1'b0;
        @(negedge clk);
        check("t5_idle_bsel", 64'(ua_b_bytesel), 64'h0);

        // write then back-to-back read
        ua_h_addr = 32'h300; ua_h_wr_en = 1'b1; ua_h_wdata = 32'hDEADBEEF; ua_h_bytesel = 4'b0011;
        @(negedge clk);
        ua_h_bytesel = 4'h0;
        check("t6_waddr",  64'(ua_b_addr), 64'h300);
        check("t6_wdata",  64'(ua_b_wdata), 64'hBEEF);
        check("t6_wbsel",  64'(ua_b_bytesel), 64'h3);
        check("t6_wr",     64'(ua_b_wr_en), 64'h1);
        ua_b_compl = 1'b1;
        @(negedge clk);
        ua_b_compl = 1'b0;
        check("t6_wcompl", 64'(ua_h_compl), 64'h1);
        check("t6_werr",   64'(ua_h_err), 64'h0);
        @(negedge clk);
        check("t6_gap_bsel", 64'(ua_b_bytesel), 64'h0);
        ua_h_addr = 32'h304; ua_h_wr_en = 1'b0; ua_h_bytesel = 4'b1100;
        @(negedge clk);
        ua_h_bytesel = 4'h0;
        check("t6_raddr", 64'(ua_b_addr), 64'h306);
        check("t6_rbsel", 64'(ua_b_bytesel), 64'h3);
        check("t6_rd",    64'(ua_b_wr_en), 64'h0);
        ua_b_compl = 1'b1; ua_b_rdata = 16'hCAFE;
        @(negedge clk);
        ua_b_compl = 1'b0;
        check("t6_rcompl", 64'(ua_h_compl), 64'h1);
        check("t6_rdata",  64'(ua_h_rdata), 64'hCAFE0000);
        @(negedge clk);
        check("t6_no_extra_beat", 64'(ua_b_bytesel), 64'h0);
        check("t6_compl_pulse",   64'(ua_h_compl), 64'h0);

        // 64/16 sparse write with 2 wait cycles per beat
        ub_h_addr = 32'h2008; ub_h_wr_en = 1'b1; ub_h_wdata = 64'h8877665544332211; ub_h_bytesel = 8'hC3;
        @(negedge clk);
        ub_h_bytesel = 8'h0;
        for (int i = 0; i < 3; i++) begin
            check("t2_addr0", 64'(ub_b_addr), 64'h2008);
            check("t2_wdata0", 64'(ub_b_wdata), 64'h2211);
            check("t2_bsel0", 64'(ub_b_bytesel), 64'h3);
            if (i == 2) ub_b_compl = 1'b1;
            @(negedge clk);
        end
        ub_b_compl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_addr1", 64'(ub_b_addr), 64'h200E);
            check("t2_wdata1", 64'(ub_b_wdata), 64'h8877);
            check("t2_bsel1", 64'(ub_b_bytesel), 64'h3);
            check("t2_wr", 64'(ub_b_wr_en), 64'h1);
            if (i == 2) ub_b_compl = 1'b1;
            @(negedge clk);
        end
        ub_b_compl = 1'b0;
        check("t2_compl", 64'(ub_h_compl), 64'h1);
        check("t2_err",   64'(ub_h_err), 64'h0);
        check("t2_bsel_done", 64'(ub_b_bytesel), 64'h0);
        @(negedge clk);
        check("t2_compl_pulse", 64'(ub_h_compl), 64'h0);

        // 32/8 single-lane read
        uc_h_addr = 32'h400; uc_h_wr_en = 1'b0; uc_h_bytesel = 4'b0100;
        @(negedge clk);
        uc_h_bytesel = 4'h0;
        check("t3_addr", 64'(uc_b_addr), 64'h402);
        check("t3_bsel", 64'(uc_b_bytesel), 64'h1);
        uc_b_compl = 1'b1; uc_b_rdata = 8'h77;
        @(negedge clk);
        uc_b_compl = 1'b0;
        check("t3_compl", 64'(uc_h_compl), 64'h1);
        check("t3_rdata", 64'(uc_h_rdata), 64'h00770000);
        check("t3_err",   64'(uc_h_err), 64'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
